// File: rtl/program_counter.sv
// Program-counter stage: forms next PC from base/offset selects, holds PC, PC_A
// and a one-deep interrupt return address, and sequences single-level interrupt entry/return.
module program_counter #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [WIDTH-1:0] INT_VECTOR   = 16'h0004
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       PC_OFFSETX,
  input  logic [1:0]       PC_BASEX,
  input  logic [WIDTH-1:0] DIN,
  input  logic             PC_LD_EN,
  input  logic             PC_A_LD,
  input  logic             INT_REQ,
  input  logic             INT_EN,
  input  logic             RETI,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_A,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             IN_ISR,
  output logic             INT_ACK
);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] TWO_C   = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] ALIGN_C = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t           state_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_a_r;
  logic [WIDTH-1:0] saved_r;
  logic             in_isr_r;
  logic             int_ack_r;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] offset_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] pc_next_s;

  // Base/offset selection and halfword-aligned sum; wraps modulo 2^WIDTH.
  always_comb begin
    base_s   = ZERO_C;
    offset_s = ZERO_C;
    case (PC_BASEX)
      2'b00:   base_s = pc_a_r;
      2'b01:   base_s = ZERO_C;
      2'b10:   base_s = pc_r;
      default: base_s = ZERO_C;
    endcase
    case (PC_OFFSETX)
      2'b00:   offset_s = ZERO_C;
      2'b01:   offset_s = TWO_C;
      2'b10:   offset_s = DIN;
      default: offset_s = ZERO_C;
    endcase
    sum_s     = base_s + offset_s;
    pc_next_s = sum_s & ALIGN_C;
  end

  // PC, PC_A, return address and interrupt sequencing state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_RUN;
      pc_r      <= RESET_VECTOR;
      pc_a_r    <= RESET_VECTOR;
      saved_r   <= ZERO_C;
      in_isr_r  <= 1'b0;
      int_ack_r <= 1'b0;
    end else begin
      int_ack_r <= 1'b0;
      if (PC_A_LD) begin
        pc_a_r <= pc_r;
      end
      if (PC_LD_EN) begin
        case (state_r)
          ST_RUN: begin
            if (RETI) begin
              pc_r <= pc_next_s;
            end else if (INT_REQ && INT_EN) begin
              saved_r   <= pc_next_s;
              pc_r      <= INT_VECTOR;
              in_isr_r  <= 1'b1;
              int_ack_r <= 1'b1;
              state_r   <= ST_ISR;
            end else begin
              pc_r <= pc_next_s;
            end
          end
          ST_ISR: begin
            // No nesting: INT_REQ is not looked at while in the handler.
            if (RETI) begin
              pc_r     <= saved_r;
              in_isr_r <= 1'b0;
              state_r  <= ST_RUN;
            end else begin
              pc_r <= pc_next_s;
            end
          end
          default: begin
            state_r  <= ST_RUN;
            in_isr_r <= 1'b0;
            pc_r     <= pc_next_s;
          end
        endcase
      end
    end
  end

  assign PC      = pc_r;
  assign PC_A    = pc_a_r;
  assign PC_NEXT = pc_next_s;
  assign IN_ISR  = in_isr_r;
  assign INT_ACK = int_ack_r;

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Registered program-counter stage directly downstream of the branch logic.
- Consumes PC_OFFSETX/PC_BASEX selects and the data-bus operand, forms next PC = base + offset, and holds PC, PC_A (address of the instruction being executed) and a one-deep interrupt return address.
- Drives the fetch address to the memory interface and sequences single-level interrupt entry and return.

Parameters:
- WIDTH, 16, address/data width in bits.
- RESET_VECTOR, 16'h0000, PC and PC_A value after reset.
- INT_VECTOR, 16'h0004, PC loaded on interrupt entry.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- PC_OFFSETX  input  2  offset select: 00 = 0, 01 = 2 (PC_OFFSETX_2), 10 = DIN (PC_OFFSETX_DIN), 11 = 0 (reserved).
- PC_BASEX  input  2  base select: 00 = PC_A (PC_BASEX_PC_A), 01 = 0 (PC_BASEX_0), 10 = PC, 11 = 0 (reserved).
- DIN  input  WIDTH  jump target or signed relative displacement.
- PC_LD_EN  input  1  load PC with the next-PC value this cycle.
- PC_A_LD  input  1  capture current PC into PC_A (instruction fetch).
- INT_REQ  input  1  level interrupt request.
- INT_EN  input  1  global interrupt enable.
- RETI  input  1  return from interrupt, qualified by PC_LD_EN.
- PC  output  WIDTH  current fetch address.
- PC_A  output  WIDTH  address of the current instruction.
- PC_NEXT  output  WIDTH  combinational next-PC (base + offset) before interrupt/RETI override.
- IN_ISR  output  1  high while in the interrupt handler.
- INT_ACK  output  1  one-cycle pulse on interrupt entry.

Behaviour:
- Reset (async, RESET_N=0): PC=RESET_VECTOR, PC_A=RESET_VECTOR, saved return address=0, IN_ISR=0, INT_ACK=0. State=RUN. Any operation in flight is abandoned. Release is synchronous to the next CLK edge.
- PC_NEXT = base + offset, modulo 2^WIDTH; bit 0 forced to 0.
  - DIN is treated as two's complement, so a relative jump backward wraps correctly; 16'hFFFE + 2 = 16'h0000.
- Base uses the registered PC_A and PC values, i.e. the values from before the edge.
- State RUN, on a PC_LD_EN edge:
  - If RETI=1: PC <= PC_NEXT (RETI outside an ISR is a plain load; no error).
  - Else if INT_REQ & INT_EN: saved <= PC_NEXT, PC <= INT_VECTOR, IN_ISR <= 1, INT_ACK <= 1 for one cycle, go to ISR.
  - Else: PC <= PC_NEXT.
- State ISR, on a PC_LD_EN edge:
  - If RETI=1: PC <= saved, IN_ISR <= 0, go to RUN. A pending INT_REQ is not taken on this edge; it is taken at the next PC_LD_EN at the earliest.
  - Else: PC <= PC_NEXT. INT_REQ is ignored (no nesting).
- PC_LD_EN=0: PC, saved and state hold; INT_REQ is not sampled.
- PC_A_LD=1: PC_A <= PC, using the pre-edge PC. This is independent of PC_LD_EN, and both may occur in the same cycle.
- INT_ACK is registered. It is low in every cycle except the one following entry.
- Latency: PC updates one clock after PC_LD_EN. PC_NEXT is zero-latency combinational.

Test Plan:
- Reset mid-run: PC=16'h0120, assert RESET_N=0 between edges -> PC=PC_A=16'h0000 and IN_ISR=0 immediately, without waiting for a clock edge.
- Sequential fetch: PC=16'h0010, PC_A_LD=1, PC_LD_EN=1, BASEX=10, OFFSETX=01 -> PC=16'h0012, PC_A=16'h0010.
- Absolute jump: BASEX=01, OFFSETX=10, DIN=16'h0400, PC_LD_EN=1 -> PC=16'h0400. Odd DIN 16'h0401 -> PC=16'h0400.
- Relative backward plus wrap:
  - PC_A=16'h0008, BASEX=00, OFFSETX=10, DIN=16'hFFF8 -> PC=16'h0000.
  - PC=16'hFFFE, BASEX=10, OFFSETX=01 -> PC=16'h0000.
- Interrupt entry and return:
  - PC=16'h0030, INT_REQ=1, INT_EN=1, sequential load -> PC=16'h0004, IN_ISR=1, INT_ACK pulses for exactly one cycle, saved=16'h0032.
  - A further INT_REQ in ISR is ignored.
  - RETI with PC_LD_EN -> PC=16'h0032, IN_ISR=0.
- Simultaneous: RETI=1 and INT_REQ=1 in ISR -> return to 16'h0032 with no INT_ACK. Next PC_LD_EN with INT_REQ still high -> entry to 16'h0004.
